// File: rtl/b_ser_pkg.sv
// Shared widths, state encoding and word-framing helper for the b_ser return path.
package b_ser_pkg;

    localparam int unsigned DW     = 135;
    localparam int unsigned CW     = 6;
    localparam int unsigned NCHUNK = (DW + CW - 1) / CW;
    localparam int unsigned CNT_W  = $clog2(NCHUNK);
    localparam int unsigned PW     = NCHUNK * CW;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Zero-extend a word to a whole number of chunks; the pad bits form the top of the last chunk.
    function automatic logic [PW-1:0] pad_word(input logic [DW-1:0] w);
        return PW'(w);
    endfunction

endpackage

// File: rtl/b_ser_fifo.sv
// DEPTH x WIDTH synchronous FIFO with registered storage and show-ahead read data.
module b_ser_fifo
    import b_ser_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = DW
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNTW-1:0]  count_q;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_q + CNTW'(push) - CNTW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count_q == CNTW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/b_ser.sv
// b_ser: buffers 135-bit words from c and serializes them LSB-first as 6-bit chunks.
// Optional macro B_SER_PARITY_EN places even parity of the word in bit 3 of the last chunk.
module b_ser
    import b_ser_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] c_b_0,
    input  logic          c_b_1,
    output logic          b_c_0,
    output logic [CW-1:0] b_c_1,
    output logic          busy,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam int unsigned FCW = $clog2(DEPTH) + 1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [PW-1:0]    shreg;
    logic [PW-1:0]    shreg_nxt;
    logic [PW-1:0]    frame;
    logic             b_c_0_nxt;
    logic [CW-1:0]    b_c_1_nxt;
    logic             busy_nxt;
    logic             ovf_nxt;

    logic             fifo_full;
    logic             fifo_empty;
    logic [DW-1:0]    fifo_rdata;
    logic [FCW-1:0]   fifo_count;
    logic [FCW-1:0]   fifo_count_nxt;
    logic             pop;
    logic             push;
    logic             drop;

    // A pop frees the slot at the same edge, so a full FIFO still accepts a word then.
    assign pop            = (state == IDLE) && !fifo_empty;
    assign push           = c_b_1 && (!fifo_full || pop);
    assign drop           = c_b_1 && fifo_full && !pop;
    assign fifo_count_nxt = fifo_count + FCW'(push) - FCW'(pop);

    b_ser_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (c_b_0),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        frame = pad_word(fifo_rdata);
`ifdef B_SER_PARITY_EN
        frame[DW] = ^fifo_rdata;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(NCHUNK)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // cnt counts chunks already presented; reaching NCHUNK forces the idle framing cycle.
    always_comb begin
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        b_c_0_nxt = 1'b0;
        b_c_1_nxt = '0;
        case (state)
            IDLE: begin
                if (pop) begin
                    b_c_0_nxt = 1'b1;
                    b_c_1_nxt = frame[CW-1:0];
                    shreg_nxt = frame >> CW;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            SHIFT: begin
                if (cnt != CNT_W'(NCHUNK)) begin
                    b_c_0_nxt = 1'b1;
                    b_c_1_nxt = shreg[CW-1:0];
                    shreg_nxt = shreg >> CW;
                    cnt_nxt   = cnt + CNT_W'(1);
                end else begin
                    cnt_nxt = '0;
                end
            end
            default: begin
                cnt_nxt = '0;
            end
        endcase
        ovf_nxt  = drop || (ovf && !ovf_clr);
        busy_nxt = (fifo_count_nxt != '0) || (state_nxt == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            shreg <= '0;
            b_c_0 <= 1'b0;
            b_c_1 <= '0;
            busy  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
            b_c_0 <= b_c_0_nxt;
            b_c_1 <= b_c_1_nxt;
            busy  <= busy_nxt;
            ovf   <= ovf_nxt;
        end
    end

endmodule
